fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, byte address of the first fetch after reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: halt_req  input  1  level; while high, no new memory request is issued.
REQ-005 SHALL have port: redirect_valid  input  1  branch/jump taken this cycle, from the branching stage.
REQ-006 SHALL have port: redirect_pc  input  32  branch/jump target byte address.
REQ-007 SHALL have port: imem_req  output  1  instruction memory request.
REQ-008 SHALL have port: imem_addr  output  32  request byte address.
REQ-009 SHALL have port: imem_ack  input  1  memory response valid, one cycle per request.
REQ-010 SHALL have port: imem_rdata  input  32  instruction word, valid with imem_ack.
REQ-011 SHALL have port: instr_valid  output  1  held instruction available to decode.
REQ-012 SHALL have port: instr_ready  input  1  decode accepts the instruction.
REQ-013 SHALL have port: instr_data  output  32  held instruction word.
REQ-014 SHALL have port: instr_pc  output  32  byte address of instr_data, fed to the branching stage as its current pc.
REQ-015 SHALL have port: align_err  output  1  sticky flag for a misaligned redirect target.

Function
REQ-016 SHALL implement FSM states IDLE (no request), REQ (request outstanding) and HOLD (instruction held for decode).
REQ-017 SHALL keep a fetch pc register; imem_addr SHALL equal the pc whenever imem_req=1.
REQ-018 SHALL drive imem_req=1 only in REQ; imem_req and imem_addr SHALL stay stable until the cycle imem_ack=1.
REQ-019 SHALL, in IDLE, move to REQ next cycle when halt_req=0, else stay in IDLE.
REQ-020 SHALL, in REQ with imem_ack=1 and no squash pending and no redirect, capture imem_rdata into instr_data and pc into instr_pc, then move to HOLD.
REQ-021 SHALL drive instr_valid=1 only in HOLD, with instr_data and instr_pc stable until the handshake.
REQ-022 SHALL, on instr_valid&instr_ready, set pc to instr_pc+4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0), then move to REQ if halt_req=0, else to IDLE.
REQ-023 SHALL clear redirect_pc[1:0] to 2'b00 before use, and set align_err when they are nonzero; align_err is cleared only by reset.
REQ-024 SHALL, on redirect_valid in IDLE, load pc with the target and stay in IDLE.
REQ-025 SHALL, on redirect_valid in HOLD, drop the held instruction, load pc with the target, and move to REQ (or IDLE if halt_req=1); redirect takes priority over a same-cycle handshake, and that instruction counts as not accepted.
REQ-026 SHALL, on redirect_valid in REQ without imem_ack, set a squash flag and store the target; the current request SHALL stay unchanged until acknowledged.
REQ-027 SHALL, when further redirects arrive while squash is pending, keep the latest target.
REQ-028 SHALL, on imem_ack while squash is pending or with a same-cycle redirect, discard imem_rdata, clear squash, load pc with the latest target, and move to REQ (or IDLE if halt_req=1).
REQ-029 SHALL let halt_req never abort an outstanding request or a held instruction; halt takes effect only at the next decision point.
REQ-030 SHALL give a latency of one cycle from entering REQ with imem_ack=1 to instr_valid=1.

Reset
REQ-031 SHALL, while rst_n=0, force state IDLE, pc=RESET_PC, squash=0, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr_data=0, instr_pc=0 and align_err=0, independent of clk.
REQ-032 SHALL, on reset assertion mid-request, abandon the request; a later imem_ack with no request outstanding SHALL be ignored.

Verification
REQ-033 Reset release with halt_req=0, zero-wait memory returning 32'hA; ready=1 -> imem_addr 0, 4, 8...; instr_pc 0, 4, 8 with matching data.
REQ-034 In REQ at addr 0x10, redirect to 0x40 two cycles before ack -> ack data discarded; next request at 0x40; no instr_valid for 0x10.
REQ-035 HOLD at 0x20 with instr_ready=1 and redirect 0x80 in the same cycle -> 0x20 not accepted; next imem_addr=0x80.
REQ-036 Redirect to 0x43 -> next imem_addr=0x40, align_err=1 and it stays set until rst_n=0.
REQ-037 pc=32'hFFFF_FFFC accepted -> next imem_addr=0; halt_req=1 during HOLD -> IDLE after handshake, no imem_req until halt_req=0.
REQ-038 rst_n pulsed low mid-REQ -> all outputs at reset values asynchronously; first request after release at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit: pc register, memory request FSM, held instruction for decode
// Redirects arriving mid-request are parked as a squash and applied when the request is acknowledged.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt_req,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        align_err
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        squash;
  logic [31:0] squash_pc;
  logic [31:0] redirect_tgt;

  assign redirect_tgt = {redirect_pc[31:2], 2'b00};
  // The request address is the pc register itself, so it cannot drift while a request is open.
  assign imem_addr    = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      squash      <= 1'b0;
      squash_pc   <= RESET_PC;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr_data  <= 32'h0;
      instr_pc    <= 32'h0;
      align_err   <= 1'b0;
    end else begin
      if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
        align_err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (redirect_valid) begin
            pc <= redirect_tgt;
          end else if (!halt_req) begin
            state    <= REQ;
            imem_req <= 1'b1;
          end
        end
        REQ: begin
          if (imem_ack) begin
            if (squash || redirect_valid) begin
              // A same-cycle redirect is newer than any parked target.
              pc       <= redirect_valid ? redirect_tgt : squash_pc;
              squash   <= 1'b0;
              state    <= halt_req ? IDLE : REQ;
              imem_req <= !halt_req;
            end else begin
              instr_data  <= imem_rdata;
              instr_pc    <= pc;
              instr_valid <= 1'b1;
              imem_req    <= 1'b0;
              state       <= HOLD;
            end
          end else if (redirect_valid) begin
            squash    <= 1'b1;
            squash_pc <= redirect_tgt;
          end
        end
        HOLD: begin
          if (redirect_valid || instr_ready) begin
            pc          <= redirect_valid ? redirect_tgt : instr_pc + 32'd4;
            instr_valid <= 1'b0;
            state       <= halt_req ? IDLE : REQ;
            imem_req    <= !halt_req;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
